// File: rtl/gpu_ram_arbiter.sv
// gpu_ram_arbiter: shares the GPU local RAM port between host, load/store and prefetch.
// Define PROG_STARVE_EN to build the prefetch starvation counter and its priority override.
module gpu_ram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [21:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [21:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  input  logic        progreq,
  input  logic [21:0] progaddr,
  input  logic        pabort,
  output logic        progack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [21:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic [1:0]  owner
);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_PROG = 2'b01;
  localparam logic [1:0] OWN_LS   = 2'b10;
  localparam logic [1:0] OWN_HOST = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t      state, state_nx;
  logic        mem_req_nx, mem_we_nx;
  logic [21:0] mem_addr_nx;
  logic [31:0] mem_wdata_nx, rdata_nx;
  logic [1:0]  owner_nx, grant;
  logic        host_ack_nx, ls_ack_nx, progack_nx;
  logic        aborted, aborted_nx;
  logic        prog_cand, force_prog, drop;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("gpu_ram_arbiter: STARVE_LIMIT must be in 1..15");
  end

  assign prog_cand = progreq & ~pabort;
  // An abort seen at any point of a prefetch memory cycle drops its result.
  assign drop = (owner == OWN_PROG) && (aborted || pabort);

`ifdef PROG_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt, starve_cnt_nx;

  assign force_prog = prog_cand && (starve_cnt == LIMIT);

  always_comb begin
    starve_cnt_nx = starve_cnt;
    if (state == IDLE) begin
      if (!progreq || grant == OWN_PROG)
        starve_cnt_nx = '0;
      else if (prog_cand && grant != OWN_NONE && starve_cnt != LIMIT)
        starve_cnt_nx = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_cnt <= '0;
    else       starve_cnt <= starve_cnt_nx;
  end
`else
  assign force_prog = 1'b0;
`endif

  always_comb begin
    grant = OWN_NONE;
    if (force_prog)     grant = OWN_PROG;
    else if (host_req)  grant = OWN_HOST;
    else if (ls_req)    grant = OWN_LS;
    else if (prog_cand) grant = OWN_PROG;
  end

  always_comb begin
    state_nx     = state;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    rdata_nx     = rdata;
    owner_nx     = owner;
    aborted_nx   = aborted;
    host_ack_nx  = 1'b0;
    ls_ack_nx    = 1'b0;
    progack_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant != OWN_NONE) begin
          state_nx   = BUSY;
          mem_req_nx = 1'b1;
          owner_nx   = grant;
          aborted_nx = 1'b0;
          unique case (grant)
            OWN_HOST: begin
              mem_we_nx    = host_we;
              mem_addr_nx  = host_addr;
              mem_wdata_nx = host_wdata;
            end
            OWN_LS: begin
              mem_we_nx    = ls_we;
              mem_addr_nx  = ls_addr;
              mem_wdata_nx = ls_wdata;
            end
            default: begin
              mem_we_nx    = 1'b0;
              mem_addr_nx  = progaddr;
              mem_wdata_nx = '0;
            end
          endcase
        end
      end
      BUSY: begin
        if (owner == OWN_PROG && pabort) aborted_nx = 1'b1;
        if (mem_ack) begin
          state_nx   = ACK;
          mem_req_nx = 1'b0;
          if (!mem_we && !drop) rdata_nx = mem_rdata;
          host_ack_nx = (owner == OWN_HOST);
          ls_ack_nx   = (owner == OWN_LS);
          progack_nx  = (owner == OWN_PROG) && !drop;
        end
      end
      default: begin
        // Requesters drop their req during this cycle, so no arbitration here.
        state_nx = IDLE;
        owner_nx = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      owner     <= OWN_NONE;
      aborted   <= 1'b0;
      host_ack  <= 1'b0;
      ls_ack    <= 1'b0;
      progack   <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      rdata     <= rdata_nx;
      owner     <= owner_nx;
      aborted   <= aborted_nx;
      host_ack  <= host_ack_nx;
      ls_ack    <= ls_ack_nx;
      progack   <= progack_nx;
    end
  end

endmodule

// File: tb/tb_gpu_ram_arbiter.sv
// tb_gpu_ram_arbiter: directed and randomized rounds against a transaction-level arbitration model.
// Follows PROG_STARVE_EN to choose the expected arbitration rule.
module tb_gpu_ram_arbiter;

  localparam int LIMIT = 2;
  localparam logic [1:0] NONE = 2'b00, PROG = 2'b01, LS = 2'b10, HOST = 2'b11;

  logic        clk, reset;
  logic        host_req, host_we, ls_req, ls_we, progreq, pabort, mem_ack;
  logic [21:0] host_addr, ls_addr, progaddr;
  logic [31:0] host_wdata, ls_wdata, mem_rdata;
  logic        host_ack, ls_ack, progack, mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata, rdata;
  logic [1:0]  owner;

  int          errors = 0;
  int          checks = 0;
  int          starve = 0;
  logic [31:0] exp_rdata = '0;

  gpu_ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ack(ls_ack),
    .progreq(progreq), .progaddr(progaddr), .pabort(pabort), .progack(progack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rdata(rdata), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Who should win given the requests currently presented to an idle arbiter.
  function automatic logic [1:0] model_winner();
    bit cand = progreq && !pabort;
`ifdef PROG_STARVE_EN
    if (cand && starve == LIMIT) return PROG;
`endif
    if (host_req) return HOST;
    if (ls_req)   return LS;
    if (cand)     return PROG;
    return NONE;
  endfunction

  task automatic model_decide(input logic [1:0] win);
    if (!progreq || win == PROG) starve = 0;
    else if (progreq && !pabort && win != NONE) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
  endtask

  task automatic idle_tick();
    if (!progreq) starve = 0;
    @(negedge clk);
  endtask

  // One full arbitration round, starting at a negedge of an idle cycle with requests set up.
  task automatic do_round(input int lat, input int abort_at, input logic [31:0] rd_val,
                          output logic [1:0] obs_owner);
    logic [1:0]  win;
    logic        we;
    logic [21:0] addr;
    logic [31:0] wd;
    bit          ab = 0;
    win = model_winner();
    model_decide(win);
    case (win)
      HOST:    begin we = host_we; addr = host_addr; wd = host_wdata; end
      LS:      begin we = ls_we;   addr = ls_addr;   wd = ls_wdata;   end
      default: begin we = 1'b0;    addr = progaddr;  wd = '0;         end
    endcase
    @(negedge clk);
    obs_owner = owner;
    check("grant_owner", owner, win);
    check("grant_mem_req", mem_req, 1);
    check("grant_mem_we", mem_we, we);
    check("grant_mem_addr", mem_addr, addr);
    if (we) check("grant_mem_wdata", mem_wdata, wd);
    for (int c = 1; c <= 1 + lat; c++) begin
      if (c > 1) begin
        @(negedge clk);
        check("busy_mem_req", mem_req, 1);
        check("busy_no_ack", {host_ack, ls_ack, progack}, 0);
      end
      pabort = (c == abort_at);
      if (c == abort_at) begin progreq = 1'b0; ab = 1; end
      mem_ack = (c == 1 + lat);
      if (mem_ack) mem_rdata = rd_val;
    end
    @(negedge clk);
    pabort = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    if (!we && !ab) exp_rdata = rd_val;
    check("ack_host", host_ack, win == HOST);
    check("ack_ls", ls_ack, win == LS);
    check("ack_prog", progack, win == PROG && !ab);
    check("ack_rdata", rdata, exp_rdata);
    check("ack_mem_req", mem_req, 0);
    case (win)
      HOST:    host_req = 1'b0;
      LS:      ls_req = 1'b0;
      default: progreq = 1'b0;
    endcase
    @(negedge clk);
    check("idle_owner", owner, NONE);
    check("idle_acks", {host_ack, ls_ack, progack}, 0);
    check("idle_mem_req", mem_req, 0);
  endtask

  initial begin
    logic [1:0] o, w;
    logic [1:0] starve_seq [3];
    int lat, ab_at;
    reset = 1'b1;
    {host_req, host_we, ls_req, ls_we, progreq, pabort, mem_ack} = '0;
    {host_addr, ls_addr, progaddr} = '0;
    {host_wdata, ls_wdata, mem_rdata} = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    check("reset_rdata", rdata, 0);
    check("reset_owner", owner, NONE);
    check("reset_acks", {host_ack, ls_ack, progack}, 0);
    reset = 1'b0;
    idle_tick();

    // Single zero-wait prefetch read.
    progreq = 1'b1; progaddr = 22'h000100;
    do_round(0, -1, 32'h9800_1234, o);
    check("prog_read_owner", o, PROG);
    check("prog_read_rdata", rdata, 32'h9800_1234);

    // All three at once: served host, ls, prog.
    host_req = 1'b1; host_we = 1'b0; host_addr = 22'h0000AA;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 22'h0000BB;
    progreq = 1'b1; progaddr = 22'h0000CC;
    do_round(0, -1, $urandom, o); check("order_first", o, HOST);
    do_round(0, -1, $urandom, o); check("order_second", o, LS);
    do_round(0, -1, $urandom, o); check("order_third", o, PROG);

    // ls held continuously against a waiting prefetch.
`ifdef PROG_STARVE_EN
    starve_seq = '{LS, LS, PROG};
`else
    starve_seq = '{LS, LS, LS};
`endif
    progreq = 1'b1; progaddr = 22'h000200;
    for (int r = 0; r < 3; r++) begin
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 22'($urandom);
      do_round(0, -1, $urandom, o);
      check("starve_round", o, starve_seq[r]);
    end
    while (host_req || ls_req || progreq) do_round(0, -1, $urandom, o);

    // Prefetch aborted while its slow memory cycle is in flight.
    progreq = 1'b1; progaddr = 22'h000300;
    do_round(4, 2, 32'hCAFE_F00D, o);
    check("abort_rdata_kept", rdata, exp_rdata);

    // ls write at the top address.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 22'h3FFFFF; ls_wdata = 32'hDEADBEEF;
    do_round(1, -1, 32'h1111_2222, o);
    check("ls_write_owner", o, LS);

    // pabort in IDLE keeps the prefetcher out of the decision.
    progreq = 1'b1; pabort = 1'b1; progaddr = 22'h000400;
    @(negedge clk);
    check("idle_abort_mem_req", mem_req, 0);
    check("idle_abort_owner", owner, NONE);
    progreq = 1'b0; pabort = 1'b0;
    idle_tick();

    // Randomized rounds.
    for (int i = 0; i < 40; i++) begin
      if (!host_req && $urandom_range(0, 2) == 0) begin
        host_req = 1'b1; host_we = 1'($urandom); host_addr = 22'($urandom); host_wdata = $urandom;
      end
      if (!ls_req && $urandom_range(0, 1) == 0) begin
        ls_req = 1'b1; ls_we = 1'($urandom); ls_addr = 22'($urandom); ls_wdata = $urandom;
      end
      if (!progreq && ($urandom_range(0, 1) == 0 || !(host_req || ls_req))) begin
        progreq = 1'b1; progaddr = 22'($urandom);
      end
      lat = $urandom_range(0, 3);
      w = model_winner();
      ab_at = (w == PROG && $urandom_range(0, 3) == 0) ? $urandom_range(1, 1 + lat) : -1;
      do_round(lat, ab_at, $urandom, o);
    end
    while (host_req || ls_req || progreq) do_round(0, -1, $urandom, o);

    // Reset in the middle of a memory cycle, then the held request completes.
    host_req = 1'b1; host_we = 1'b0; host_addr = 22'h001234;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_mem_req", mem_req, 0);
    check("midreset_owner", owner, NONE);
    check("midreset_acks", {host_ack, ls_ack, progack}, 0);
    check("midreset_rdata", rdata, 0);
    exp_rdata = '0;
    starve = 0;
    @(negedge clk);
    reset = 1'b0;
    do_round(1, -1, 32'h5A5A_A5A5, o);
    check("after_reset_owner", o, HOST);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
